// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants, queue entry type and sizing helper for the fetch stage
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam int          FETCH_QDEPTH  = 2;
  localparam int          FETCH_MAX_OUT = 2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Width of a counter that must hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order FIFO with combinational head, used for fetch addresses and the instr/pc queue
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  // flush beats push and pop; a same-cycle pop frees the slot a push on a full FIFO needs
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop && !flush));

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - IF stage: issues pc to imem, queues returned instrs with their pc, hands them to ID
// Defining FETCH_PERF_CNT_EN adds the perf_fetched/perf_stall counters.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int          QDEPTH  = FETCH_QDEPTH,
  parameter int          MAX_OUT = FETCH_MAX_OUT,
  parameter logic [31:0] NOP     = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        flush,
  output logic        fetch_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] id_pc,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
`else
  output logic [31:0] id_pc
`endif
);

  localparam int QCW = cnt_w(QDEPTH);
  localparam int OCW = cnt_w(MAX_OUT);

  logic           run_q;
  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] discard_q;
  logic [OCW-1:0] discard_d;
  logic [QCW-1:0] q_count;
  logic [31:0]    addr_head;
  fetch_entry_t   q_wdata;
  fetch_entry_t   q_head;
  logic           credit_ok;
  logic           slot_ok;
  logic           accept;
  logic           resp_keep;
  logic           id_pop;

  // Holds requests off until the first clock after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  assign credit_ok   = (32'(q_count) + 32'(outstanding)) < 32'(QDEPTH);
  assign slot_ok     = 32'(outstanding) < 32'(MAX_OUT);
  assign imem_req    = run_q & credit_ok & slot_ok & ~flush;
  assign imem_addr   = pc;
  assign accept      = imem_req & imem_gnt;
  assign fetch_stall = ~accept;

  // The address FIFO occupancy is the in-flight request count.
  fetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_addr_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (accept),
    .push_data (pc),
    .pop       (imem_rvalid),
    .flush     (1'b0),
    .head_data (addr_head),
    .count     (outstanding)
  );

  assign resp_keep = imem_rvalid & (discard_q == '0);

  always_comb begin
    discard_d = discard_q;
    if (flush)                                discard_d = outstanding - OCW'(imem_rvalid);
    else if (imem_rvalid && discard_q != '0)  discard_d = discard_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) discard_q <= '0;
    else      discard_q <= discard_d;
  end

  assign q_wdata = '{instr: imem_rdata, pc: addr_head};
  assign id_pop  = id_valid & id_ready;

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(QDEPTH)) u_instr_q (
    .clk       (clk),
    .rst_n     (rst),
    .push      (resp_keep),
    .push_data (q_wdata),
    .pop       (id_pop),
    .flush     (flush),
    .head_data (q_head),
    .count     (q_count)
  );

  assign id_valid = (q_count != '0);
  assign id_instr = id_valid ? q_head.instr : NOP;
  assign id_pc    = id_valid ? q_head.pc : 32'h0;

  assert property (@(posedge clk) disable iff (!rst) !(imem_rvalid && outstanding == '0));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (id_pop && !flush)      perf_fetched_q <= perf_fetched_q + 32'd1;
      if (fetch_stall && !flush) perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a PC-register and imem model
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic        flush = 1'b0;
  logic        fetch_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
`ifdef FETCH_PERF_CNT_EN
    .id_pc        (id_pc),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`else
    .id_pc       (id_pc)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          delivered = 0;
  int          target = 0;
  bit          ready_en = 1'b0;
  bit          resp_en = 1'b1;
  logic [31:0] redirect = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc = p;
    e.instr = i;
    exp_q.push_back(e);
  endtask

  // One clock: capture what the DUT sees at the edge, then model PC register and imem.
  task automatic tick();
    bit          acc;
    bit          fl;
    logic [31:0] a;
    logic [31:0] r;
    #2;
    acc = imem_req && imem_gnt;
    fl  = flush;
    a   = imem_addr;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    if (fl)       pc = redirect;
    else if (acc) pc = pc + 32'd4;
    if (acc) pend.push_back(a);
    if (resp_en && pend.size() > 0) begin
      r = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hC0DE_0000 | {16'h0, r[15:0]};
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    id_ready = ready_en && (delivered < target);
  endtask

  task automatic run_until(input string name, input int n, input int bound);
    for (int i = 0; i < bound && delivered < n; i++) tick();
    chk(name, delivered, n);
  endtask

  task automatic do_reset(input string tag);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    rst = 1'b0;
    flush = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    ready_en = 1'b0;
    id_ready = 1'b0;
    resp_en = 1'b1;
    pend.delete();
    exp_q.delete();
    pc = 32'h0;
    delivered = 0;
    target = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: every real ID handshake pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst && id_valid && id_ready && !flush) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got id_pc 0x%08h, expected no delivery", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id_pc", id_pc, e.pc);
        chk("sb_id_instr", id_instr, e.instr);
      end
      delivered++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("rst_id_valid", id_valid, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_fetch_stall", fetch_stall, 1);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetched", perf_fetched, 0);
`endif

    // Streaming with 1-cycle imem latency.
    do_reset("init");
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    push_exp(32'h8, 32'hC0DE_0008);
    imem_gnt = 1'b1;
    ready_en = 1'b1;
    target = 3;
    tick();
    chk("s1_req_after_release", imem_req, 1);
    tick();
    chk("s1_valid_gnt_plus1", id_valid, 0);
    tick();
    chk("s1_valid_gnt_plus2", id_valid, 1);
    run_until("s1_delivered", 3, 30);
`ifdef FETCH_PERF_CNT_EN
    chk("s1_perf_fetched", perf_fetched, 3);
`endif

    // ID back-pressure: two accepts then stall, then drain and resume.
    do_reset("s1");
    imem_gnt = 1'b1;
    repeat (11) tick();
    chk("s2_req_blocked", imem_req, 0);
    chk("s2_fetch_stall", fetch_stall, 1);
    chk("s2_pc_frozen", pc, 32'h8);
    chk("s2_head_pc", id_pc, 32'h0);
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    push_exp(32'h8, 32'hC0DE_0008);
    ready_en = 1'b1;
    target = 3;
    id_ready = 1'b1;
    run_until("s2_delivered", 3, 30);

    // Grant toggling 1,0,1.
    do_reset("s2");
    push_exp(32'h0, 32'hC0DE_0000);
    push_exp(32'h4, 32'hC0DE_0004);
    push_exp(32'h8, 32'hC0DE_0008);
    imem_gnt = 1'b1;
    ready_en = 1'b1;
    target = 3;
    tick();
    #1 chk("s3_stall_gnt1", fetch_stall, 0);
    tick();
    imem_gnt = 1'b0;
    #1 chk("s3_stall_gnt0", fetch_stall, 1);
    chk("s3_req_gnt0", imem_req, 1);
    tick();
    imem_gnt = 1'b1;
    #1 chk("s3_stall_gnt1b", fetch_stall, 0);
    run_until("s3_delivered", 3, 30);

    // Flush with two requests in flight; both late responses must be dropped.
    do_reset("s3");
    push_exp(32'h100, 32'hC0DE_0100);
    push_exp(32'h104, 32'hC0DE_0104);
    push_exp(32'h108, 32'hC0DE_0108);
    resp_en = 1'b0;
    imem_gnt = 1'b1;
    ready_en = 1'b1;
    target = 3;
    repeat (3) tick();
    chk("s4_req_max_out", imem_req, 0);
    chk("s4_pc_before_flush", pc, 32'h8);
    flush = 1'b1;
    redirect = 32'h100;
    #1 chk("s4_req_in_flush", imem_req, 0);
    tick();
    chk("s4_valid_after_flush", id_valid, 0);
    resp_en = 1'b1;
    run_until("s4_delivered", 3, 40);

    // Flush coincident with rvalid and an ID handshake.
    do_reset("s4");
    push_exp(32'h100, 32'hC0DE_0100);
    push_exp(32'h104, 32'hC0DE_0104);
    imem_gnt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_rvalid && id_valid) break;
    end
    chk("s5_rvalid_and_valid", {30'h0, imem_rvalid, id_valid}, 32'h3);
    flush = 1'b1;
    redirect = 32'h100;
    id_ready = 1'b1;
    #1 chk("s5_req_in_flush", imem_req, 0);
    ready_en = 1'b1;
    target = 2;
    tick();
    chk("s5_valid_after_flush", id_valid, 0);
    run_until("s5_delivered", 2, 40);

    // Asynchronous reset mid-stream.
    do_reset("s5");
    imem_gnt = 1'b1;
    repeat (6) tick();
    chk("s6_valid_before_rst", id_valid, 1);
    #3 rst = 1'b0;
    #1;
    chk("s6_id_valid", id_valid, 0);
    chk("s6_imem_req", imem_req, 0);
    chk("s6_fetch_stall", fetch_stall, 1);
    chk("s6_id_instr", id_instr, 32'h0000_0013);
    chk("s6_id_pc", id_pc, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("s6_perf_fetched", perf_fetched, 0);
    chk("s6_perf_stall", perf_stall, 0);
`endif
    chk("s6_sb_drained", exp_q.size(), 0);
    imem_rvalid = 1'b0;
    pend.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
